// File: rtl/leg_input_fifo_if.sv
// Producer/core handshake bundle for leg_input_fifo.
// master = producer and core side, slave = the FIFO.
interface leg_input_fifo_if;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_ready;
  logic       arch_input_enable;
  logic [7:0] arch_input_value;

  modport master (
    output src_valid, src_data, arch_input_enable,
    input  src_ready, arch_input_value
  );

  modport slave (
    input  src_valid, src_data, arch_input_enable,
    output src_ready, arch_input_value
  );
endinterface

// File: rtl/leg_input_fifo.sv
// Byte FIFO in front of the LEG core input port (circular buffer, sticky underflow).
// Optional LEG_INPUT_FIFO_BYPASS_EN: an empty-FIFO read is served straight from src_data.
module leg_input_fifo #(
  parameter int unsigned UUID  = 0,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  leg_input_fifo_if.slave        bus,
  input  logic                   clear,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // No child instances yet; UUID is kept so the hierarchy numbering stays stable.
  if (UUID == 32'hFFFF_FFFF) begin : g_uuid_rsvd
  end

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          underflow_q, underflow_d;

  logic bypass;
  logic push;
  logic pop;
  logic src_ready;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign level     = count_q;
  assign underflow = underflow_q;

  // Ready depends only on rst and registered occupancy, never on the core.
  assign src_ready     = rst & ~full;
  assign bus.src_ready = src_ready;

`ifdef LEG_INPUT_FIFO_BYPASS_EN
  assign bypass = empty & bus.src_valid & bus.arch_input_enable;
`else
  assign bypass = 1'b0;
`endif

  assign push = bus.src_valid & src_ready & ~bypass;
  assign pop  = bus.arch_input_enable & ~empty;

  always_comb begin
    if (bypass) begin
      bus.arch_input_value = bus.src_data;
    end else if (empty) begin
      bus.arch_input_value = 8'h00;
    end else begin
      bus.arch_input_value = mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      underflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (bus.arch_input_enable && empty && !bypass) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left unreset; a byte offered during clear is dropped.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_q[wr_ptr_q] <= bus.src_data;
    end
  end

endmodule

// File: doc/leg_input_fifo.md
# leg_input_fifo

Byte-wide input buffer that sits directly upstream of the LEG core's architectural input port. External producers push bytes over a valid/ready handshake, and the FIFO presents its head byte on `arch_input_value`. Each cycle the core asserts `arch_input_enable` (an IN instruction executing) consumes exactly one byte. Occupancy and underflow status are exported for the testbench and for the level harness.

## Interface

Parameters:
- `UUID`, 0, instance identifier, XORed into child UUIDs.
- `DEPTH`, 8, number of byte entries; power of two, 2..256.

Ports:
- `clk`  in  1  sole clock; rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `src_valid`  in  1  producer has a byte on `src_data`.
- `src_data`  in  8  byte offered by the producer.
- `src_ready`  out  1  FIFO accepts a byte this cycle.
- `clear`  in  1  synchronous flush.
- `arch_input_enable`  in  1  core consumes one byte this cycle.
- `arch_input_value`  out  8  byte presented to the core.
- `empty`  out  1  occupancy == 0.
- `full`  out  1  occupancy == DEPTH.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `underflow`  out  1  sticky flag: the core read while no byte was available.

## Operation

- Storage is a circular buffer indexed by `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits wide, plus a `count` register of $clog2(DEPTH)+1 bits. Both pointers wrap modulo DEPTH.
- Push occurs when `src_valid && src_ready`: the byte is written at `wr_ptr`, then `wr_ptr` increments.
- `src_ready` = `!full` while `rst` is high, and 0 while `rst` is low. It never depends on `arch_input_enable`, so there is no combinational path from core to producer.
- Pop occurs when `arch_input_enable && !empty`: `rd_ptr` increments.
- `arch_input_value` = `mem[rd_ptr]` when not empty, else 0x00 (see Configuration for the bypass case).
- Simultaneous push and pop with 0 < count < DEPTH: both pointers advance and `count` is unchanged.
- Push and pop in the same cycle while empty: the pop is an underflow. Without bypass, the pushed byte is stored, `count` becomes 1, and `underflow` sets.
- Full: `src_ready` is 0, so a pop in that cycle brings `count` to DEPTH-1. A push is possible the next cycle.
- `underflow` sets on `arch_input_enable && empty` (excluding bypass). It clears only on reset or `clear`.
- `clear` zeroes the pointers, `count` and `underflow`. It overrides any push or pop in the same cycle; a byte offered that cycle is dropped, but `src_ready` still reflects the pre-clear state.
- Memory contents are not reset.

## Timing

- Reset values: `src_ready`=0 during reset, then 1 after deassertion. `empty`=1, `full`=0, `level`=0, `underflow`=0, `arch_input_value`=0x00.
- Reset is asynchronous on assertion. Deassertion is taken at the next `clk` edge.
- Reset mid-transfer discards all buffered bytes. No handshake completes in a cycle in which `rst` is low.
- Push-to-visible latency: a byte pushed at edge N appears on `arch_input_value` after edge N if the FIFO was empty.
- Pop takes effect at the edge. The next byte is visible immediately after it.
- `empty`, `full` and `level` are registered-state derived and update one edge after the event.
- `arch_input_value` is combinational from the registered `rd_ptr` and the memory. Exception: under bypass it is combinational from `src_data`.

## Configuration

- `LEG_INPUT_FIFO_BYPASS_EN` defined: when `empty && src_valid && arch_input_enable`, `arch_input_value` = `src_data` in the same cycle.
  - The byte counts as consumed and is not written to the FIFO.
  - `src_ready` is 1, pointers and `count` are unchanged, and `underflow` does not set.
- `LEG_INPUT_FIFO_BYPASS_EN` undefined: no cut-through. The same situation is an underflow and returns 0x00, and the byte is stored for the next read.

## Test plan

- **Reset:** hold `rst`=0 for 3 cycles while driving `src_valid`=1 -> `src_ready`=0, `level`=0, `empty`=1, `arch_input_value`=0x00. After release, `src_ready`=1.
- **Ordering:** push 0x11, 0x22, 0x33, then assert `arch_input_enable` for 3 cycles -> reads 0x11, 0x22, 0x33 in order, `empty`=1, `underflow`=0.
- **Full and wrap (DEPTH=8):**
  - Push 8 bytes 0x00..0x07 -> `full`=1, `src_ready`=0, and a ninth byte held on `src_valid` is not accepted.
  - Pop one byte -> 0x00 is read, and the ninth byte is accepted on the following cycle.
  - Drain all bytes -> 0x01..0x07 then the ninth byte, confirming pointer wrap.
- **Concurrent push/pop at `level`=3:** 10 cycles of simultaneous push and pop -> `level` stays 3 and the read order is preserved.
- **Empty read:**
  - Bypass undefined: pulse `arch_input_enable` with the FIFO empty and `src_valid`=1, `src_data`=0x5A -> value 0x00, `underflow`=1, `level`=1 next cycle.
  - Bypass defined: the same stimulus -> value 0x5A, `underflow`=0, `level`=0.
- **Clear:** `clear` with `level`=5 and a concurrent push and pop -> next cycle `level`=0, `empty`=1, `underflow`=0, and the offered byte is not stored.
